// File: rtl/shift_deserializer.sv
// Serial-to-parallel deserializer with selectable bit order, one-word output buffer and sticky overrun.
// Define SHIFT_DESER_PARITY_EN to expect a trailing even-parity bit after each data word.
module shift_deserializer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             direction,
   input  logic             sin,
   input  logic             sin_valid,
   input  logic             clear,
   input  logic             q_ready,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   output logic             busy,
   output logic             overrun,
   output logic             parity_err
);

   localparam int CW = $clog2(WIDTH + 1);

`ifdef SHIFT_DESER_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

   state_t           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] shreg_q;
   logic             dir_q;
   logic [WIDTH-1:0] word_q;
   logic             q_valid_q;
   logic             busy_q;
   logic             overrun_q;
   logic             parity_err_q;

   logic             dir_d;
   logic [WIDTH-1:0] shift_d;
   logic             last_data;
   logic             done;
   logic             accept;
   logic [WIDTH-1:0] word_d;
   logic             perr_d;

   always_comb begin
      // The first bit of a word uses the live direction input; later bits use the latched copy.
      dir_d     = (state_q == IDLE) ? direction : dir_q;
      shift_d   = dir_d ? {shreg_q[WIDTH-2:0], sin} : {sin, shreg_q[WIDTH-1:1]};
      last_data = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
      accept    = !q_valid_q || q_ready;
`ifdef SHIFT_DESER_PARITY_EN
      done      = sin_valid && !clear && (state_q == PARITY);
      word_d    = shreg_q;
      perr_d    = (^shreg_q) ^ sin;
`else
      done      = sin_valid && !clear && last_data;
      word_d    = shift_d;
      perr_d    = 1'b0;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         shreg_q      <= '0;
         dir_q        <= 1'b0;
         word_q       <= '0;
         q_valid_q    <= 1'b0;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         if (done) begin
            if (accept) begin
               word_q       <= word_d;
               q_valid_q    <= 1'b1;
               parity_err_q <= perr_d;
            end else begin
               overrun_q    <= 1'b1;
            end
         end else if (q_valid_q && q_ready) begin
            q_valid_q <= 1'b0;
         end

         if (clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            busy_q  <= 1'b0;
         end else if (sin_valid) begin
            case (state_q)
               IDLE: begin
                  dir_q   <= direction;
                  shreg_q <= shift_d;
                  cnt_q   <= CW'(1);
                  state_q <= SHIFT;
                  busy_q  <= 1'b1;
               end
               SHIFT: begin
                  shreg_q <= shift_d;
                  if (last_data) begin
`ifdef SHIFT_DESER_PARITY_EN
                     cnt_q   <= cnt_q + CW'(1);
                     state_q <= PARITY;
`else
                     cnt_q   <= '0;
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
`endif
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
`ifdef SHIFT_DESER_PARITY_EN
               PARITY: begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
`endif
               default: begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign q          = word_q;
   assign q_valid    = q_valid_q;
   assign busy       = busy_q;
   assign overrun    = overrun_q;
   assign parity_err = parity_err_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Scoreboard bench for shift_deserializer (WIDTH=4); works with or without SHIFT_DESER_PARITY_EN.
module tb_shift_deserializer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       direction = 1'b1;
   logic       sin = 1'b0;
   logic       sin_valid = 1'b0;
   logic       clear = 1'b0;
   logic       q_ready = 1'b0;
   logic [3:0] q;
   logic       q_valid;
   logic       busy;
   logic       overrun;
   logic       parity_err;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [3:0] q;
      logic       perr;
   } exp_t;
   exp_t sb[$];

`ifdef SHIFT_DESER_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   shift_deserializer #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .direction(direction), .sin(sin), .sin_valid(sin_valid),
      .clear(clear), .q_ready(q_ready), .q(q), .q_valid(q_valid), .busy(busy),
      .overrun(overrun), .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   // Inputs change 1 time unit after the rising edge; outputs are read there too.
   task automatic send_bit(input logic b);
      sin = b;
      sin_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      sin_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_rst();
      #2 rst = 1'b1;
      #2 rst = 1'b0;
   endtask

   // Sends four data bits (seq[3] first) plus the parity bit when enabled and queues the expected result.
   task automatic send_word(input logic [3:0] seq, input logic [3:0] exp_q, input logic bad_par,
                            input logic exp_perr_keep);
      exp_t e;
      e.q    = exp_q;
      e.perr = PAR_EN ? (exp_perr_keep ? parity_err : bad_par) : 1'b0;
      sb.push_back(e);
      for (int i = 3; i >= 0; i--) send_bit(seq[i]);
      if (PAR_EN) send_bit((^seq) ^ bad_par);
   endtask

   task automatic check_word(input string name);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $display("FAIL %s: scoreboard empty, q=%b", name, q);
         return;
      end
      e = sb.pop_front();
      if (q !== e.q || q_valid !== 1'b1 || parity_err !== e.perr) begin
         failures++;
         $display("FAIL %s: got q=%b q_valid=%b parity_err=%b, expected q=%b q_valid=1 parity_err=%b",
                  name, q, q_valid, parity_err, e.q, e.perr);
      end else
         $display("word %s: q=%b parity_err=%b", name, q, parity_err);
   endtask

   task automatic check_bit(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end else
         $display("check %s: %b", name, got);
   endtask

   task automatic consume();
      q_ready = 1'b1;
      sin_valid = 1'b0;
      @(posedge clk);
      #1;
      q_ready = 1'b0;
      check_bit("consume_q_valid", q_valid, 1'b0);
   endtask

   task automatic test_reset();
      pulse_rst();
      check_bit("rst_q_valid", q_valid, 1'b0);
      check_bit("rst_busy", busy, 1'b0);
      check_bit("rst_overrun", overrun, 1'b0);
      check_bit("rst_parity_err", parity_err, 1'b0);
      checks++;
      if (q !== 4'b0000) begin
         failures++;
         $display("FAIL rst_q: got %b expected 0000", q);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_msb_first();
      direction = 1'b1;
      send_bit(1'b1);
      check_bit("msb_busy_mid", busy, 1'b1);
      check_bit("msb_no_valid_mid", q_valid, 1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      exp_push_and_finish(4'b1011, 1'b1);
      check_word("msb_first");
      check_bit("msb_busy_done", busy, 1'b0);
      idle(1);
      check_bit("msb_q_valid_held", q_valid, 1'b1);
      consume();
   endtask

   // Completes a word whose first three bits were already sent by the caller.
   task automatic exp_push_and_finish(input logic [3:0] exp_q, input logic last);
      exp_t e;
      e.q = exp_q;
      e.perr = 1'b0;
      sb.push_back(e);
      send_bit(last);
      if (PAR_EN) send_bit(^exp_q);
   endtask

   task automatic test_lsb_first();
      direction = 1'b0;
      send_word(4'b1011, 4'b1101, 1'b0, 1'b0);
      check_word("lsb_first");
      consume();
      direction = 1'b0;
      send_bit(1'b1);
      direction = 1'b1;
      send_bit(1'b0);
      send_bit(1'b1);
      exp_push_and_finish(4'b1101, 1'b1);
      check_word("lsb_dir_toggle");
      consume();
   endtask

   task automatic test_hold_and_clear();
      direction = 1'b1;
      send_bit(1'b1);
      send_bit(1'b0);
      idle(3);
      check_bit("hold_busy", busy, 1'b1);
      send_bit(1'b1);
      exp_push_and_finish(4'b1011, 1'b1);
      check_word("hold_gap");
      consume();
      send_bit(1'b1);
      send_bit(1'b0);
      clear = 1'b1;
      send_bit(1'b1);
      clear = 1'b0;
      check_bit("clear_busy", busy, 1'b0);
      check_bit("clear_q_valid", q_valid, 1'b0);
      send_word(4'b0110, 4'b0110, 1'b0, 1'b0);
      check_word("after_clear");
      consume();
   endtask

   task automatic test_back_to_back();
      pulse_rst();
      direction = 1'b1;
      q_ready = 1'b0;
      send_word(4'b1011, 4'b1011, 1'b0, 1'b0);
      check_word("b2b_first");
      send_word(4'b0110, 4'b1011, 1'b0, 1'b1);
      check_word("overrun_keep_q");
      check_bit("overrun_set", overrun, 1'b1);
      idle(2);
      check_bit("overrun_sticky", overrun, 1'b1);
      pulse_rst();
      check_bit("overrun_rst", overrun, 1'b0);
      send_word(4'b1011, 4'b1011, 1'b0, 1'b0);
      check_word("b2b_first_again");
      q_ready = 1'b1;
      send_word(4'b0110, 4'b0110, 1'b0, 1'b0);
      q_ready = 1'b0;
      check_word("ready_replace");
      check_bit("no_overrun", overrun, 1'b0);
      consume();
   endtask

   task automatic test_async_reset();
      direction = 1'b1;
      send_word(4'b1111, 4'b1111, 1'b0, 1'b0);
      check_word("pre_rst_word");
      send_bit(1'b1);
      send_bit(1'b0);
      sin_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check_bit("async_q_valid", q_valid, 1'b0);
      check_bit("async_busy", busy, 1'b0);
      checks++;
      if (q !== 4'b0000) begin
         failures++;
         $display("FAIL async_q: got %b expected 0000", q);
      end
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      send_word(4'b0011, 4'b0011, 1'b0, 1'b0);
      check_word("after_async_rst");
      consume();
   endtask

   task automatic test_parity();
      direction = 1'b1;
      send_word(4'b1011, 4'b1011, 1'b0, 1'b0);
      check_word("parity_good");
      consume();
      send_word(4'b1011, 4'b1011, 1'b1, 1'b0);
      check_word("parity_bad");
      consume();
   endtask

   initial begin
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_hold_and_clear();
      test_back_to_back();
      test_async_reset();
      if (PAR_EN) test_parity();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
